// File: rtl/tim_hfsm.sv
// Horizontal CCD timing FSM: parks H clocks for THD after vact rises, runs dummy and
// active pixels, then overscan; emits ADC-aligned pixel strobes through a fixed delay line.
module tim_hfsm #(
    parameter int THD     = 180,
    parameter int ADC_LAT = 8,
    parameter int DEF_DUM = 24,
    parameter int DEF_ACT = 2456
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vact,
    input  logic        sel,
    input  logic [1:0]  a,
    input  logic [7:0]  d,
    input  logic        we,
    output logic        h_run,
    output logic        rg_en,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic        line_done,
    output logic        line_abort,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_DUMMY,
        S_ACTIVE,
        S_OVER
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [11:0] x;
    } pix_t;

    localparam logic [11:0] LP_DEF_ACT = 12'(DEF_ACT);
    localparam logic [7:0]  LP_DEF_DUM = 8'(DEF_DUM);
    localparam logic [11:0] LP_THD_M1  = 12'(THD - 1);

    state_t      r_state;
    logic [11:0] r_cnt;
    logic [11:0] r_act;
    logic [7:0]  r_dum;
    logic [11:0] r_act_sh;
    logic [7:0]  r_dum_sh;
    logic        r_h_run;
    logic        r_rg_en;
    logic        r_line_abort;
    pix_t        r_pipe [ADC_LAT];

    logic [11:0] w_act_wr;
    logic        w_abort;
    pix_t        w_push;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_act_wr = r_act;
        if (a == 2'd1) begin
            w_act_wr = {d[3:0], r_act[7:0]};
        end else if (a == 2'd2) begin
            w_act_wr = {r_act[11:8], d};
        end
    end

    // NOTE: sequential state is only ever assigned with <=, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act <= LP_DEF_ACT;
            r_dum <= LP_DEF_DUM;
        end else if (sel && we) begin
            case (a)
                2'd1, 2'd2: r_act <= (w_act_wr == 12'd0) ? 12'd1 : w_act_wr;
                2'd3:       r_dum <= d;
                default:    ;
            endcase
        end
    end

    assign w_abort = !vact && (r_state == S_HOLD || r_state == S_DUMMY || r_state == S_ACTIVE);

    always_comb begin
        w_push = '0;
        if (r_state == S_ACTIVE) begin
            w_push.valid = 1'b1;
            w_push.last  = (r_cnt == 12'd0);
            w_push.x     = r_act_sh - 12'd1 - r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 12'd0;
            r_act_sh     <= LP_DEF_ACT;
            r_dum_sh     <= LP_DEF_DUM;
            r_h_run      <= 1'b0;
            r_rg_en      <= 1'b0;
            r_line_abort <= 1'b0;
            // NOTE: the delay line is reset (unlike a RAM) because an abort must flush it in one edge anyway.
            for (int i = 0; i < ADC_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_h_run      <= (r_state == S_DUMMY || r_state == S_ACTIVE || r_state == S_OVER);
            r_rg_en      <= (r_state == S_DUMMY || r_state == S_ACTIVE);
            r_line_abort <= w_abort;

            r_pipe[0] <= w_push;
            for (int i = 1; i < ADC_LAT; i++) r_pipe[i] <= r_pipe[i-1];

            case (r_state)
                S_IDLE: begin
                    if (vact) begin
                        r_state  <= S_HOLD;
                        r_cnt    <= LP_THD_M1;
                        r_act_sh <= r_act;
                        r_dum_sh <= r_dum;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else if (r_dum_sh == 8'd0) begin
                        r_state <= S_ACTIVE;
                        r_cnt   <= r_act_sh - 12'd1;
                    end else begin
                        r_state <= S_DUMMY;
                        r_cnt   <= {4'd0, r_dum_sh} - 12'd1;
                    end
                end
                S_DUMMY: begin
                    if (r_cnt != 12'd0) begin
                        r_cnt <= r_cnt - 12'd1;
                    end else begin
                        r_state <= S_ACTIVE;
                        r_cnt   <= r_act_sh - 12'd1;
                    end
                end
                S_ACTIVE: begin
                    if (r_cnt != 12'd0) r_cnt <= r_cnt - 12'd1;
                    else                r_state <= S_OVER;
                end
                S_OVER: begin
                    if (!vact) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Abort overrides the normal transition and drops every in-flight pixel.
            if (w_abort) begin
                r_state <= S_IDLE;
                r_cnt   <= 12'd0;
                for (int i = 0; i < ADC_LAT; i++) r_pipe[i] <= '0;
            end
        end
    end

    assign h_run      = r_h_run;
    assign rg_en      = r_rg_en;
    assign pix_valid  = r_pipe[ADC_LAT-1].valid;
    assign pix_x      = r_pipe[ADC_LAT-1].x;
    assign line_done  = r_pipe[ADC_LAT-1].last;
    assign line_abort = r_line_abort;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_tim_hfsm.sv
// Scoreboard bench for tim_hfsm: each line pushes its expected pixels into a queue and a
// negedge monitor pops and compares them whenever pix_valid is presented.
module tb_tim_hfsm;

    localparam int THD     = 180;
    localparam int LAT     = 8;
    localparam int DEF_DUM = 24;
    localparam int DEF_ACT = 2456;

    logic        clk;
    logic        rst;
    logic        vact;
    logic        sel;
    logic [1:0]  a;
    logic [7:0]  d;
    logic        we;
    logic        h_run;
    logic        rg_en;
    logic        pix_valid;
    logic [11:0] pix_x;
    logic        line_done;
    logic        line_abort;
    logic        busy;

    tim_hfsm #(
        .THD     (THD),
        .ADC_LAT (LAT),
        .DEF_DUM (DEF_DUM),
        .DEF_ACT (DEF_ACT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vact       (vact),
        .sel        (sel),
        .a          (a),
        .d          (d),
        .we         (we),
        .h_run      (h_run),
        .rg_en      (rg_en),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .line_done  (line_done),
        .line_abort (line_abort),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x;
        logic        last;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec      = 0;
    int   n_err      = 0;
    int   abort_seen = 0;
    int   exp_aborts = 0;
    bit   mon_en     = 1'b0;
    int   m_act      = DEF_ACT;
    int   m_dum      = DEF_DUM;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (line_abort) abort_seen++;
            if (pix_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_pix_valid", 32'(pix_valid), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("pix_x", 32'(pix_x), 32'(mon_e.x));
                    check("line_done", 32'(line_done), 32'(mon_e.last));
                end
            end else begin
                check("idle_pix", {19'd0, line_done, pix_x}, 32'd0);
            end
        end
    end

    // Drives vact high for hi clock edges starting from IDLE, optionally rewriting the
    // registers mid-line; expected pixels come from the shadowed ACT/DUM model values.
    task automatic run_line(input int hi, input bit do_wr, input logic [11:0] new_act,
                            input logic [7:0] new_dum);
        int   act  = m_act;
        int   dum  = m_dum;
        bit   full = (hi >= 1 + THD + dum + act);
        int   n;
        exp_t e;
        n = full ? act : hi - LAT - THD - dum;
        if (n < 0) n = 0;
        if (n > act) n = act;
        for (int i = 0; i < n; i++) begin
            e.x    = 12'(i);
            e.last = full && (i == act - 1);
            q.push_back(e);
        end
        if (!full) exp_aborts++;
        vact = 1'b1;
        for (int k = 0; k < hi; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_hold", 32'(busy), 32'd1);
            if (k == THD) begin
                check("h_run_parked", 32'(h_run), 32'd0);
                check("rg_en_parked", 32'(rg_en), 32'd0);
            end
            if (k == THD + 1) begin
                check("h_run_rise", 32'(h_run), 32'd1);
                check("rg_en_rise", 32'(rg_en), 32'd1);
            end
            if (n > 0 && k == THD + dum + LAT - 1) check("first_valid_early", 32'(pix_valid), 32'd0);
            if (n > 0 && k == THD + dum + LAT)     check("first_valid", 32'(pix_valid), 32'd1);
            if (full && k == THD + dum + act + 1) begin
                check("rg_en_overscan", 32'(rg_en), 32'd0);
                check("h_run_overscan", 32'(h_run), 32'd1);
            end
            if (do_wr) begin
                case (k)
                    100: begin sel = 1'b1; we = 1'b1; a = 2'd1; d = {4'hF, new_act[11:8]}; end
                    101: begin a = 2'd2; d = new_act[7:0]; end
                    102: begin a = 2'd3; d = new_dum; end
                    103: begin sel = 1'b0; d = 8'hA5; end
                    104: begin sel = 1'b1; a = 2'd0; d = 8'h5A; end
                    105: begin sel = 1'b0; we = 1'b0; end
                    default: ;
                endcase
            end
        end
        vact = 1'b0;
        if (do_wr) begin
            m_act = (new_act == 12'd0) ? 1 : int'(new_act);
            m_dum = int'(new_dum);
        end
    endtask

    task automatic drain(input string name);
        repeat (20) @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_run"},      32'(h_run),      32'd0);
        check({tag, "_rg_en"},      32'(rg_en),      32'd0);
        check({tag, "_pix_valid"},  32'(pix_valid),  32'd0);
        check({tag, "_pix_x"},      32'(pix_x),      32'd0);
        check({tag, "_line_done"},  32'(line_done),  32'd0);
        check({tag, "_line_abort"}, 32'(line_abort), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        #(600_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        vact = 1'b0;
        sel  = 1'b0;
        we   = 1'b0;
        a    = 2'd0;
        d    = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Full default line.
        run_line(2673, 1'b0, 12'd0, 8'd0);
        drain("drain_default");

        // vact falls mid-ACTIVE.
        run_line(1000, 1'b0, 12'd0, 8'd0);
        @(negedge clk);
        check("abort_pulse", 32'(line_abort), 32'd1);
        check("abort_valid_low", 32'(pix_valid), 32'd0);
        @(negedge clk);
        check("abort_one_shot", 32'(line_abort), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        drain("drain_abort");

        // Mid-line write of ACT=0x100, DUM=0 leaves this line at defaults.
        run_line(2673, 1'b1, 12'h100, 8'd0);
        drain("drain_wr_line");

        // 256-pixel line straight from HOLD into ACTIVE; writes ACT=0 (stored as 1), DUM=3.
        run_line(1 + THD + 256 + 4, 1'b1, 12'h000, 8'd3);
        drain("drain_256");

        // Single-pixel line; writes ACT=0x100, DUM=5.
        run_line(1 + THD + 3 + 1 + 2, 1'b1, 12'h100, 8'd5);
        drain("drain_one_pixel");

        // Two minimum-length lines with a 3-cycle vact gap.
        run_line(1 + THD + 5 + 256, 1'b0, 12'd0, 8'd0);
        repeat (3) @(negedge clk);
        run_line(1 + THD + 5 + 256, 1'b0, 12'd0, 8'd0);
        drain("drain_two_lines");

        // Reset asserted while in DUMMY.
        vact = 1'b1;
        repeat (THD + 3) @(negedge clk);
        check("h_run_pre_rst", 32'(h_run), 32'd1);
        rst  = 1'b1;
        vact = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst   = 1'b0;
        m_act = DEF_ACT;
        m_dum = DEF_DUM;
        @(negedge clk);

        // Defaults restored: full default line again.
        run_line(2673, 1'b0, 12'd0, 8'd0);
        drain("drain_after_rst");

        check("abort_count", 32'(abort_seen), 32'(exp_aborts));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
